// File: rtl/cheriot_dv_pkg.sv
// Shared DV types for CHERIoT monitors: memory command records and stored request entries.
package cheriot_dv_pkg;

  localparam int unsigned MemMonMaxOutstanding = 2;

  // Completed data-memory transaction as consumed by the scoreboard and capability checkers.
  typedef struct packed {
    logic [7:0]  flag;
    logic        is_cap;
    logic        we;
    logic [3:0]  be;
    logic [29:0] addr32;
    logic [32:0] wdata;
    logic [32:0] rdata;
    logic        err;
  } mem_cmd_t;

  typedef struct packed {
    logic [7:0]  flag;
    logic        is_cap;
    logic        we;
    logic [3:0]  be;
    logic [29:0] addr32;
    logic [32:0] wdata;
  } mem_req_ent_t;

  function automatic mem_cmd_t mem_cmd_from_req(input mem_req_ent_t req,
                                                input logic [32:0] rdata,
                                                input logic        err);
    mem_cmd_t cmd;
    cmd.flag   = req.flag;
    cmd.is_cap = req.is_cap;
    cmd.we     = req.we;
    cmd.be     = req.be;
    cmd.addr32 = req.addr32;
    cmd.wdata  = req.wdata;
    cmd.rdata  = rdata;
    cmd.err    = err;
    return cmd;
  endfunction

endpackage

// File: rtl/cheriot_dv_sync_fifo.sv
// Small synchronous FIFO for DV monitors; head is presented combinationally from storage.
module cheriot_dv_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  // Pointers run modulo 2*Depth; the top bit distinguishes full from empty.
  logic [CntW-1:0]  wptr_q, wptr_d;
  logic [CntW-1:0]  rptr_q, rptr_d;
  logic             do_push, do_pop;

  function automatic logic [IdxW-1:0] idx(input logic [CntW-1:0] ptr);
    logic [CntW-1:0] masked;
    masked = ptr & CntW'(Depth - 1);
    return IdxW'(masked);
  endfunction

  always_comb begin
    count_o = wptr_q - rptr_q;
    empty_o = (count_o == '0);
    full_o  = (count_o == CntW'(Depth));
    rdata_o = mem_q[idx(rptr_q)];
  end

  // A pop frees the head slot, so a push while full is accepted if a pop happens alongside.
  always_comb begin
    do_pop  = pop_i & ~empty_o;
    do_push = push_i & (~full_o | do_pop);
    wptr_d  = do_push ? wptr_q + CntW'(1) : wptr_q;
    rptr_d  = do_pop  ? rptr_q + CntW'(1) : rptr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[idx(wptr_q)] <= wdata_i;
    end
  end

endmodule

// File: rtl/cheriot_mem_cmd_mon.sv
// Passive monitor pairing granted data-memory requests with in-order responses into records.
module cheriot_mem_cmd_mon
  import cheriot_dv_pkg::*;
#(
  parameter int unsigned MaxOutstanding = MemMonMaxOutstanding,
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            data_req_i,
  input  logic            data_gnt_i,
  input  logic            data_we_i,
  input  logic [3:0]      data_be_i,
  input  logic [31:0]     data_addr_i,
  input  logic [32:0]     data_wdata_i,
  input  logic            data_is_cap_i,
  input  logic [7:0]      flag_i,
  input  logic            data_rvalid_i,
  input  logic [32:0]     data_rdata_i,
  input  logic            data_err_i,
  output logic            mem_cmd_valid_o,
  output mem_cmd_t        mem_cmd_o,
  output logic [CntW-1:0] outstanding_o,
  output logic            overflow_o,
  output logic            orphan_rsp_o
);

  localparam int unsigned EntW = $bits(mem_req_ent_t);

  mem_req_ent_t    push_ent, head_ent;
  logic [EntW-1:0] head_raw;
  logic            grant, fifo_full, fifo_empty, rsp_ok;
  logic [CntW-1:0] fifo_count;

  logic     mem_cmd_valid_q, mem_cmd_valid_d;
  mem_cmd_t mem_cmd_q, mem_cmd_d;
  logic     overflow_q, overflow_d;
  logic     orphan_q, orphan_d;

  always_comb begin
    grant           = data_req_i & data_gnt_i;
    push_ent.flag   = flag_i;
    push_ent.is_cap = data_is_cap_i;
    push_ent.we     = data_we_i;
    push_ent.be     = data_be_i;
    push_ent.addr32 = data_addr_i[31:2];
    push_ent.wdata  = data_we_i ? data_wdata_i : 33'h0;
    head_ent        = mem_req_ent_t'(head_raw);
  end

  cheriot_dv_sync_fifo #(
    .Width (EntW),
    .Depth (MaxOutstanding)
  ) u_req_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (grant),
    .wdata_i (push_ent),
    .pop_i   (data_rvalid_i),
    .rdata_o (head_raw),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Full implies non-empty, so a same-cycle rvalid always frees a slot for the grant.
  always_comb begin
    rsp_ok          = data_rvalid_i & ~fifo_empty;
    mem_cmd_valid_d = rsp_ok;
    mem_cmd_d       = mem_cmd_q;
    if (rsp_ok) begin
      mem_cmd_d = mem_cmd_from_req(head_ent, head_ent.we ? 33'h0 : data_rdata_i, data_err_i);
    end
    overflow_d = overflow_q | (grant & fifo_full & ~data_rvalid_i);
    orphan_d   = orphan_q | (data_rvalid_i & fifo_empty);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_cmd_valid_q <= 1'b0;
      mem_cmd_q       <= '0;
      overflow_q      <= 1'b0;
      orphan_q        <= 1'b0;
    end else begin
      mem_cmd_valid_q <= mem_cmd_valid_d;
      mem_cmd_q       <= mem_cmd_d;
      overflow_q      <= overflow_d;
      orphan_q        <= orphan_d;
    end
  end

  always_comb begin
    mem_cmd_valid_o = mem_cmd_valid_q;
    mem_cmd_o       = mem_cmd_q;
    outstanding_o   = fifo_count;
    overflow_o      = overflow_q;
    orphan_rsp_o    = orphan_q;
  end

endmodule

// File: tb/tb_cheriot_mem_cmd_mon.sv
// Directed self-checking bench for cheriot_mem_cmd_mon with MaxOutstanding=2.
module tb_cheriot_mem_cmd_mon;
  import cheriot_dv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, gnt, we, is_cap, rvalid, err;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [32:0] wdata, rdata;
  logic [7:0]  flag;
  logic        cmd_valid, overflow, orphan;
  mem_cmd_t    cmd;
  logic [1:0]  outstanding;

  int checks = 0;
  int errors = 0;

  cheriot_mem_cmd_mon #(
    .MaxOutstanding (2)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .data_req_i      (req),
    .data_gnt_i      (gnt),
    .data_we_i       (we),
    .data_be_i       (be),
    .data_addr_i     (addr),
    .data_wdata_i    (wdata),
    .data_is_cap_i   (is_cap),
    .flag_i          (flag),
    .data_rvalid_i   (rvalid),
    .data_rdata_i    (rdata),
    .data_err_i      (err),
    .mem_cmd_valid_o (cmd_valid),
    .mem_cmd_o       (cmd),
    .outstanding_o   (outstanding),
    .overflow_o      (overflow),
    .orphan_rsp_o    (orphan)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic mem_cmd_t mk(input logic [7:0] f, input logic c, input logic w,
                                  input logic [3:0] b, input logic [29:0] a,
                                  input logic [32:0] wd, input logic [32:0] rd,
                                  input logic e);
    mem_cmd_t m;
    m.flag = f; m.is_cap = c; m.we = w; m.be = b; m.addr32 = a;
    m.wdata = wd; m.rdata = rd; m.err = e;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req = 0; gnt = 0; we = 0; is_cap = 0; rvalid = 0; err = 0;
    be = 4'h0; addr = 32'h0; wdata = 33'h0; rdata = 33'h0; flag = 8'h0;
  endtask

  task automatic grant(input logic [31:0] a, input logic w, input logic [3:0] b,
                       input logic [32:0] wd, input logic c, input logic [7:0] f);
    req = 1; gnt = 1; addr = a; we = w; be = b; wdata = wd; is_cap = c; flag = f;
  endtask

  task automatic no_grant();
    req = 0; gnt = 0; addr = 32'hFFFF_FFFF; wdata = 33'h1_5555_5555;
  endtask

  task automatic rsp(input logic [32:0] rd, input logic e);
    rvalid = 1; rdata = rd; err = e;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  initial begin
    idle();
    rst_n = 0;
    tick();
    tick();
    chk("reset_valid", cmd_valid, 0);
    chk("reset_cmd", cmd, 0);
    chk("reset_outstanding", outstanding, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_orphan", orphan, 0);
    rst_n = 1;

    // Single read; wdata on the bus must not be stored for a read.
    grant(32'h8000_0004, 0, 4'hf, 33'h1_FFFF_FFFF, 0, 8'h5a);
    tick();
    chk("rd_outstanding_1", outstanding, 1);
    chk("rd_no_strobe_yet", cmd_valid, 0);
    no_grant();
    rsp(33'h1_DEAD_BEEF, 0);
    tick();
    chk("rd_strobe", cmd_valid, 1);
    chk("rd_record", cmd, mk(8'h5a, 0, 0, 4'hf, 30'h2000_0001, 33'h0, 33'h1_DEAD_BEEF, 0));
    chk("rd_outstanding_0", outstanding, 0);
    idle();
    tick();
    chk("rd_strobe_one_cycle", cmd_valid, 0);

    // Write with error; rdata on the bus must be dropped for a write.
    grant(32'h8000_0020, 1, 4'h3, 33'h0_1234_5678, 0, 8'h11);
    tick();
    no_grant();
    rsp(33'h1_AAAA_AAAA, 1);
    tick();
    chk("wr_strobe", cmd_valid, 1);
    chk("wr_record", cmd, mk(8'h11, 0, 1, 4'h3, 30'h2000_0008, 33'h0_1234_5678, 33'h0, 1));
    idle();

    // Overlapped capability pair.
    grant(32'h8000_0010, 0, 4'hf, 33'h0, 1, 8'h21);
    tick();
    chk("cap_outstanding_a", outstanding, 1);
    grant(32'h8000_0014, 0, 4'hf, 33'h0, 1, 8'h22);
    rsp(33'h1_0000_1111, 0);
    tick();
    chk("cap_strobe_a", cmd_valid, 1);
    chk("cap_record_a", cmd, mk(8'h21, 1, 0, 4'hf, 30'h2000_0004, 33'h0, 33'h1_0000_1111, 0));
    chk("cap_outstanding_b", outstanding, 1);
    no_grant();
    rsp(33'h1_0000_2222, 0);
    tick();
    chk("cap_strobe_b", cmd_valid, 1);
    chk("cap_record_b", cmd, mk(8'h22, 1, 0, 4'hf, 30'h2000_0005, 33'h0, 33'h1_0000_2222, 0));
    chk("cap_outstanding_c", outstanding, 0);
    idle();
    tick();

    // Overflow: third grant dropped while full.
    grant(32'h8000_0040, 0, 4'hf, 33'h0, 0, 8'h31);
    tick();
    grant(32'h8000_0044, 0, 4'hf, 33'h0, 0, 8'h32);
    tick();
    chk("ovf_not_yet", overflow, 0);
    chk("ovf_full_count", outstanding, 2);
    grant(32'h8000_0048, 0, 4'hf, 33'h0, 0, 8'h33);
    tick();
    chk("ovf_set", overflow, 1);
    chk("ovf_count_held", outstanding, 2);
    no_grant();
    rsp(33'h0_0000_0031, 0);
    tick();
    chk("ovf_rec_1", cmd, mk(8'h31, 0, 0, 4'hf, 30'h2000_0010, 33'h0, 33'h0_0000_0031, 0));
    rsp(33'h0_0000_0032, 0);
    tick();
    chk("ovf_strobe_2", cmd_valid, 1);
    chk("ovf_rec_2", cmd, mk(8'h32, 0, 0, 4'hf, 30'h2000_0011, 33'h0, 33'h0_0000_0032, 0));
    chk("ovf_drained", outstanding, 0);
    chk("ovf_no_orphan", orphan, 0);
    idle();
    tick();
    chk("ovf_sticky", overflow, 1);

    // Pure orphan response.
    do_reset();
    chk("reset_clears_overflow", overflow, 0);
    rsp(33'h1_0BAD_0BAD, 0);
    tick();
    chk("orphan_set", orphan, 1);
    chk("orphan_no_strobe", cmd_valid, 0);
    idle();

    // Same-cycle grant and rvalid while empty: orphan, but the grant is kept.
    do_reset();
    grant(32'h8000_0080, 0, 4'h1, 33'h0, 0, 8'h44);
    rsp(33'h1_0000_0000, 0);
    tick();
    chk("orphan2_set", orphan, 1);
    chk("orphan2_no_strobe", cmd_valid, 0);
    chk("orphan2_outstanding", outstanding, 1);
    no_grant();
    rsp(33'h0_0000_0044, 0);
    tick();
    chk("orphan2_record", cmd, mk(8'h44, 0, 0, 4'h1, 30'h2000_0020, 33'h0, 33'h0_0000_0044, 0));
    idle();

    // Asynchronous reset mid-flight.
    do_reset();
    grant(32'h8000_0100, 0, 4'hf, 33'h0, 0, 8'h51);
    tick();
    grant(32'h8000_0104, 0, 4'hf, 33'h0, 0, 8'h52);
    rsp(33'h1_0000_0051, 0);
    tick();
    chk("mid_strobe_before", cmd_valid, 1);
    chk("mid_outstanding_before", outstanding, 1);
    idle();
    #1;
    rst_n = 0;
    #1;
    chk("mid_rst_valid", cmd_valid, 0);
    chk("mid_rst_cmd", cmd, 0);
    chk("mid_rst_outstanding", outstanding, 0);
    #1;
    rst_n = 1;
    rsp(33'h1_0000_0052, 0);
    tick();
    chk("mid_orphan", orphan, 1);
    chk("mid_no_strobe", cmd_valid, 0);
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
